fetch_unit: RTL and testbench

Instruction fetch stage of the MIPS core: it owns the program counter, drives the address of the combinational instruction memory, and holds the fetched word in an output register for decode. Consumers use a valid/ready handshake. The block also accepts branch, jump and jump-register redirects from decode/execute. A misaligned jump-register target halts fetching until reset.

---
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, captures the instruction word into a
// valid/ready output register, and applies jr/jump/branch redirects from downstream.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc4,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        fault
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        fault_q, fault_d;

    logic        accept_s;
    logic        load_en_s;
    logic        redirect_s;
    logic        bad_jr_s;
    logic [31:0] target_s;

    assign accept_s  = valid_q & out_ready;
    assign load_en_s = (~valid_q | out_ready) & (state_q == ST_RUN);

    // Redirect selection by priority; targets are relative to the instruction being accepted
    always_comb begin
        redirect_s = 1'b0;
        bad_jr_s   = 1'b0;
        target_s   = 32'h0000_0000;
        if (jr) begin
            redirect_s = 1'b1;
            bad_jr_s   = (jr_target[1:0] != 2'b00);
            target_s   = jr_target;
        end else if (jump) begin
            redirect_s = 1'b1;
            target_s   = {pc4_q[31:28], jump_index, 2'b00};
        end else if (branch_taken) begin
            redirect_s = 1'b1;
            target_s   = pc4_q + (branch_offset << 2);
        end else begin
            redirect_s = 1'b0;
        end
    end

    // Next-state logic for the PC, output register and RUN/HALT machine
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        fault_d = fault_q;
        case (state_q)
            ST_RUN: begin
                if (accept_s && redirect_s && bad_jr_s) begin
                    fault_d = 1'b1;
                    valid_d = 1'b0;
                    state_d = ST_HALT;
                end else if (accept_s && redirect_s) begin
                    // the word fetched this cycle is on the wrong path: drop it
                    pc_d    = target_s;
                    valid_d = 1'b0;
                end else if (load_en_s) begin
                    instr_d = imem_data;
                    pc4_d   = pc_q + 32'd4;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd4;
                end else begin
                    valid_d = valid_q;
                end
            end
            ST_HALT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = ST_HALT;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= 32'h0000_0000;
            pc4_q   <= 32'h0000_0000;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            fault_q <= fault_d;
        end
    end

    assign imem_addr = pc_q;
    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_pc4   = pc4_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall, redirects, priority,
// PC wrap, misaligned-jr halt and asynchronous reset.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic        fault;

    int n_pass  = 0;
    int n_total = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc4      (out_pc4),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .jump_index   (jump_index),
        .jr           (jr),
        .jr_target    (jr_target),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: word at address a is a ^ 32'hA5A5_0000
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_out(input string tag, input logic [31:0] pc4, input logic [31:0] addr);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_pc4"}, out_pc4, pc4);
        check({tag, "_instr"}, out_instr, mem_word(pc4 - 32'd4));
        check({tag, "_addr"}, imem_addr, addr);
    endtask

    task automatic check_bubble(input string tag, input logic [31:0] addr);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_addr"}, imem_addr, addr);
    endtask

    task automatic clear_redirects();
        branch_taken  = 1'b0;
        branch_offset = 32'h0000_0000;
        jump          = 1'b0;
        jump_index    = 26'd0;
        jr            = 1'b0;
        jr_target     = 32'h0000_0000;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_addr"}, imem_addr, 32'h0000_0000);
        check({tag, "_instr"}, out_instr, 32'h0000_0000);
        check({tag, "_pc4"}, out_pc4, 32'h0000_0000);
        check({tag, "_fault"}, {31'd0, fault}, 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        out_ready = 1'b1;
        clear_redirects();

        // Reset, then sequential fetch
        #12;
        check_reset_values("rst");
        @(negedge clk); reset = 1'b1;
        @(negedge clk); check_out("seq0", 32'd4, 32'd4);
        @(negedge clk); check_out("seq1", 32'd8, 32'd8);

        // Back-pressure for 3 cycles while out_pc4 = 8
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); check_out("stall", 32'd8, 32'd8);
        end
        out_ready = 1'b1;
        @(negedge clk); check_out("resume0", 32'd12, 32'd12);
        @(negedge clk); check_out("resume1", 32'd16, 32'd16);

        // Branch backwards to 0 from out_pc4 = 8
        reset = 1'b0;
        #1 check_reset_values("rst2");
        @(negedge clk); reset = 1'b1;
        @(negedge clk); check_out("br_pre0", 32'd4, 32'd4);
        @(negedge clk); check_out("br_pre1", 32'd8, 32'd8);
        branch_taken  = 1'b1;
        branch_offset = 32'hFFFF_FFFE;
        @(negedge clk); check_bubble("br_bub", 32'd0);
        clear_redirects();
        @(negedge clk); check_out("br_tgt", 32'd4, 32'd4);
        @(negedge clk); check_out("pri_pre0", 32'd8, 32'd8);
        @(negedge clk); check_out("pri_pre1", 32'd12, 32'd12);

        // jr beats jump beats branch
        jr            = 1'b1;
        jr_target     = 32'h0000_0020;
        jump          = 1'b1;
        jump_index    = 26'd2;
        branch_taken  = 1'b1;
        branch_offset = 32'h0000_0001;
        @(negedge clk); check_bubble("pri_jr_bub", 32'h20);
        clear_redirects();
        @(negedge clk); check_out("pri_jr", 32'h24, 32'h24);

        // jump beats branch
        jump          = 1'b1;
        jump_index    = 26'd2;
        branch_taken  = 1'b1;
        branch_offset = 32'h0000_0001;
        @(negedge clk); check_bubble("pri_j_bub", 32'h8);
        clear_redirects();
        @(negedge clk); check_out("pri_j", 32'hC, 32'hC);

        // Forward branch: 0xC + 3*4 = 0x18
        branch_taken  = 1'b1;
        branch_offset = 32'h0000_0003;
        @(negedge clk); check_bubble("brf_bub", 32'h18);
        clear_redirects();
        @(negedge clk); check_out("brf", 32'h1C, 32'h1C);

        // jr to the top word: pc + 4 wraps silently to 0
        jr        = 1'b1;
        jr_target = 32'hFFFF_FFFC;
        @(negedge clk); check_bubble("wrap_bub", 32'hFFFF_FFFC);
        clear_redirects();
        @(negedge clk); check_out("wrap0", 32'h0, 32'h0);
        @(negedge clk); check_out("wrap1", 32'h4, 32'h4);

        // Misaligned jr: fault, halt, pc frozen at 4
        jr        = 1'b1;
        jr_target = 32'h0000_0022;
        @(negedge clk);
        check("flt_fault", {31'd0, fault}, 32'd1);
        check_bubble("flt", 32'h4);
        jump       = 1'b1;
        jump_index = 26'd7;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("halt_fault", {31'd0, fault}, 32'd1);
            check_bubble("halt", 32'h4);
        end
        clear_redirects();
        @(posedge clk); #2 reset = 1'b0;
        #1 check_reset_values("rst_halt");

        // Asynchronous reset during a stall with a redirect pending
        @(negedge clk); reset = 1'b1;
        @(negedge clk); check_out("st_pre", 32'd4, 32'd4);
        out_ready  = 1'b0;
        jump       = 1'b1;
        jump_index = 26'd5;
        @(negedge clk); check_out("st_hold", 32'd4, 32'd4);
        @(posedge clk); #2 reset = 1'b0;
        #1 check_reset_values("rst_stall");
        clear_redirects();
        @(negedge clk); reset = 1'b1; out_ready = 1'b1;
        @(negedge clk); check_out("post0", 32'd4, 32'd4);
        @(negedge clk); check_out("post1", 32'd8, 32'd8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
